// File: rtl/assist_mode_ctrl.sv
// Assist-level front end: synchronised/debounced buttons, long-press on down,
// brake inhibit and a slew-limited torque scale output.

module amc_debounce #(
  parameter int DEB_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic lvl_o
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic          s1_q, s2_q, lvl_q, lvl_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Level flips on the edge where the count would reach DEB_CYC.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == DEB_LAST) lvl_d = s2_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl_o = lvl_q;
endmodule

module assist_mode_ctrl #(
  parameter int DEB_CYC  = 1000,
  parameter int LONG_CYC = 50000,
  parameter int RAMP_CYC = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       brake_n,
  output logic [1:0] setting,
  output logic [2:0] scale,
  output logic       ramping
);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam int RW = $clog2(RAMP_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] TMR_LAST  = RW'(RAMP_CYC - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  // Index 0 = up, 1 = down.
  logic [1:0] raw_btn, deb_lvl, prev_q;
  assign raw_btn = {btn_dn, btn_up};

  for (genvar g = 0; g < 2; g++) begin : g_deb
    amc_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (raw_btn[g]),
      .lvl_o (deb_lvl[g])
    );
  end

  logic          brk1_q, brk2_q, brk;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    setting_q, setting_d;
  logic [2:0]    scale_q, scale_d, tgt;
  logic [RW-1:0] tmr_q, tmr_d;
  state_t        state_q, state_d;
  logic          up_evt, dn_short, dn_long;

  assign brk = ~brk2_q;

  // Hold saturates at LONG_CYC, so a saturated count marks a consumed long press.
  assign hold_d   = !deb_lvl[1] ? '0 : (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
  assign up_evt   = deb_lvl[0] & ~prev_q[0];
  assign dn_short = ~deb_lvl[1] & prev_q[1] & (hold_q != HOLD_MAX);
  assign dn_long  = deb_lvl[1] & (hold_q == HOLD_LAST);

  always_comb begin
    setting_d = setting_q;
    if (dn_long)
      setting_d = 2'd0;
    else if (dn_short)
      setting_d = (setting_q == 2'd0) ? 2'd0 : setting_q - 2'd1;
    else if (up_evt && !brk)
      setting_d = (setting_q == 2'd3) ? 2'd3 : setting_q + 2'd1;
  end

  always_comb begin
    case (setting_q)
      2'd0:    tgt = 3'd0;
      2'd1:    tgt = 3'd3;
      2'd2:    tgt = 3'd5;
      default: tgt = 3'd7;
    endcase
    if (brk) tgt = 3'd0;
  end

  // Timer free-runs across target changes; each wrap moves scale one LSB.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    scale_d = scale_q;
    if (brk) begin
      state_d = IDLE;
      tmr_d   = '0;
      scale_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          tmr_d = '0;
          if (scale_q != tgt) state_d = RAMP;
        end
        default: begin
          if (scale_q == tgt) begin
            state_d = IDLE;
            tmr_d   = '0;
          end else if (tmr_q == TMR_LAST) begin
            tmr_d   = '0;
            scale_d = (scale_q > tgt) ? scale_q - 3'd1 : scale_q + 3'd1;
            if (scale_d == tgt) state_d = IDLE;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk1_q    <= 1'b1;
      brk2_q    <= 1'b1;
      prev_q    <= 2'b00;
      hold_q    <= '0;
      setting_q <= 2'd2;
      scale_q   <= 3'd5;
      tmr_q     <= '0;
      state_q   <= IDLE;
    end else begin
      brk1_q    <= brake_n;
      brk2_q    <= brk1_q;
      prev_q    <= deb_lvl;
      hold_q    <= hold_d;
      setting_q <= setting_d;
      scale_q   <= scale_d;
      tmr_q     <= tmr_d;
      state_q   <= state_d;
    end
  end

  assign setting = setting_q;
  assign scale   = scale_q;
  assign ramping = (state_q == RAMP);
endmodule

// File: tb/tb_assist_mode_ctrl.sv
// Directed bench for assist_mode_ctrl with short debounce/hold/ramp periods.

module tb_assist_mode_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, btn_up, btn_dn, brake_n;
  logic [1:0] setting;
  logic [2:0] scale;
  logic       ramping;
  int         tests = 0;
  int         fails = 0;

  assist_mode_ctrl #(.DEB_CYC(4), .LONG_CYC(20), .RAMP_CYC(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .brake_n (brake_n),
    .setting (setting),
    .scale   (scale),
    .ramping (ramping)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_up(input int hi, input int lo);
    btn_up = 1'b1;
    repeat (hi) tick();
    btn_up = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic press_dn(input int hi, input int lo);
    btn_dn = 1'b1;
    repeat (hi) tick();
    btn_dn = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    rst_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; brake_n = 1'b1;
    repeat (3) tick();
    chk("rst_setting", 8'(setting), 8'd2);
    chk("rst_scale",   8'(scale),   8'd5);
    chk("rst_ramping", 8'(ramping), 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_setting", 8'(setting), 8'd2);
      chk("idle_scale",   8'(scale),   8'd5);
      chk("idle_ramping", 8'(ramping), 8'd0);
    end

    // Up press: setting changes on edge 7, scale 5->6->7 at edges 11,14.
    btn_up = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk("up_setting", 8'(setting), (e < 7) ? 8'd2 : 8'd3);
      chk("up_scale",   8'(scale),   (e < 11) ? 8'd5 : (e < 14) ? 8'd6 : 8'd7);
      chk("up_ramping", 8'(ramping), (e >= 8 && e <= 13) ? 8'd1 : 8'd0);
      if (e == 10) btn_up = 1'b0;
    end
    press_up(8, 12);
    chk("up_sat_setting", 8'(setting), 8'd3);
    chk("up_sat_scale",   8'(scale),   8'd7);

    // Glitches shorter than the debounce window.
    for (int k = 0; k < 5; k++) begin
      btn_dn = 1'b1;
      repeat (3) tick();
      btn_dn = 1'b0;
      repeat (3) tick();
      chk("glitch_ramping", 8'(ramping), 8'd0);
    end
    repeat (10) tick();
    chk("glitch_setting", 8'(setting), 8'd3);
    chk("glitch_scale",   8'(scale),   8'd7);

    // Long press: setting 0 on edge 26; scale 7->0 one LSB per 3 cycles.
    btn_dn = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      tick();
      chk("long_setting", 8'(setting), (e < 26) ? 8'd3 : 8'd0);
      chk("long_scale",   8'(scale),
          (e < 30) ? 8'd7 : (e >= 48) ? 8'd0 : 8'(7 - (e - 27) / 3));
      chk("long_ramping", 8'(ramping), (e >= 27 && e <= 47) ? 8'd1 : 8'd0);
      if (e == 40) btn_dn = 1'b0;
    end

    press_up(8, 12);
    press_up(8, 40);
    chk("pre_brk_setting", 8'(setting), 8'd2);
    chk("pre_brk_scale",   8'(scale),   8'd5);
    chk("pre_brk_ramping", 8'(ramping), 8'd0);

    // Brake forces scale 0 on edge 3, blocks up, still honours down.
    brake_n = 1'b0;
    tick(); tick();
    chk("brk_e2_scale", 8'(scale), 8'd5);
    tick();
    chk("brk_e3_scale",   8'(scale),   8'd0);
    chk("brk_e3_ramping", 8'(ramping), 8'd0);
    press_up(8, 12);
    chk("brk_up_ignored", 8'(setting), 8'd2);
    chk("brk_up_scale",   8'(scale),   8'd0);
    press_dn(8, 12);
    chk("brk_dn_setting", 8'(setting), 8'd1);
    chk("brk_dn_scale",   8'(scale),   8'd0);
    chk("brk_dn_ramping", 8'(ramping), 8'd0);

    // Release: scale 0->1->2->3 at edges 6,9,12.
    brake_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk("rel_scale",   8'(scale),   (e < 6) ? 8'd0 : (e < 9) ? 8'd1 : (e < 12) ? 8'd2 : 8'd3);
      chk("rel_ramping", 8'(ramping), (e >= 3 && e <= 11) ? 8'd1 : 8'd0);
    end

    // Up rise and dn fall debounce in the same cycle: only the decrement applies.
    btn_dn = 1'b1;
    repeat (8) tick();
    btn_dn = 1'b0;
    btn_up = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      chk("coinc_setting", 8'(setting), (e < 7) ? 8'd1 : 8'd0);
    end
    chk("coinc_ramping", 8'(ramping), 8'd1);
    chk("coinc_scale",   8'(scale),   8'd2);

    // Asynchronous reset mid-ramp.
    rst_n  = 1'b0;
    btn_up = 1'b0;
    #1;
    chk("mid_rst_setting", 8'(setting), 8'd2);
    chk("mid_rst_scale",   8'(scale),   8'd5);
    chk("mid_rst_ramping", 8'(ramping), 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("post_rst_setting", 8'(setting), 8'd2);
    chk("post_rst_scale",   8'(scale),   8'd5);
    chk("post_rst_ramping", 8'(ramping), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
